hybridift_axi_slice128: RTL

// - Full AXI register slice on all five channels of the 128-bit CPU-to-memory path.
// - Sits directly upstream of hybridift_axi_slave128: CPU/bus side enters on *_s0, buffered side drives the slave's *_s0 inputs via *_m0.
// - Cuts every combinational valid/ready path between CPU and slave (slave's arready/awready depend on arvalid in IDLE).
// - Keeps full throughput (one beat/cycle/channel) and preserves ordering.

---
 rtl/hybridift_axi128_pkg.sv | 56 +++++
 rtl/hybridift_axi_skid.sv | 75 +++++++
 rtl/hybridift_axi_slice128.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/hybridift_axi128_pkg.sv
// Shared types for the 128-bit CPU-to-memory AXI path.
// Each *_chan_t packs one channel's payload and leaves out valid/ready.
// Fields are listed MSB-first, in the same order the top level uses to
// pack and unpack the bundles.
package hybridift_axi128_pkg;

  localparam int ID_W   = 8;
  localparam int ADDR_W = 40;
  localparam int DATA_W = 128;
  localparam int STRB_W = 16;

  // Write address: 68 bits.
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic [3:0]        cache;
    logic [2:0]        prot;
  } aw_chan_t;

  // Write data: 153 bits.
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic              last;
  } w_chan_t;

  // Write response: 10 bits.
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } b_chan_t;

  // Read address: 68 bits.
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic [3:0]        cache;
    logic [2:0]        prot;
  } ar_chan_t;

  // Read data: 139 bits.
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } r_chan_t;

endpackage

// File: rtl/hybridift_axi_skid.sv
// Two-entry skid buffer for one AXI channel.
// The buffer has a main register that drives the outputs and a skid register
// that holds one beat while the sink stalls.
// Handshake: a beat transfers on a rising clk edge when valid and ready are
// both high. A source holds valid and its data stable until it sees ready,
// and valid never drops without a transfer.
// Ports:
//   clk, rst_b          clock and asynchronous active-low reset
//   in_valid/in_ready   upstream handshake; in_data carries the payload
//   out_valid/out_ready downstream handshake; out_data carries the payload
// With SLICE=0 the channel is plain wires.
module hybridift_axi_skid #(
  parameter type T     = logic,
  parameter bit  SLICE = 1'b1
) (
  input  logic clk,
  input  logic rst_b,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  if (SLICE) begin : g_reg
    logic main_vld;
    logic skid_vld;
    T     main_data;
    T     skid_data;
    logic in_fire;
    logic main_free;

    // in_ready depends only on a register, so no ready path runs through.
    assign in_ready  = !skid_vld;
    assign out_valid = main_vld;
    assign out_data  = main_data;
    assign in_fire   = in_valid && in_ready;
    // main_free means main is empty or is being consumed this cycle.
    // Skid is only ever occupied while main is full.
    assign main_free = !main_vld || out_ready;

    always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
        main_vld  <= 1'b0;
        skid_vld  <= 1'b0;
        main_data <= '0;
        skid_data <= '0;
      end else if (main_free) begin
        // When skid holds a beat, in_ready is low, so no new beat can
        // arrive in the same cycle.
        if (skid_vld) begin
          main_data <= skid_data;
          main_vld  <= 1'b1;
          skid_vld  <= 1'b0;
        end else if (in_fire) begin
          main_data <= in_data;
          main_vld  <= 1'b1;
        end else begin
          main_vld  <= 1'b0;
        end
      end else if (in_fire) begin
        skid_data <= in_data;
        skid_vld  <= 1'b1;
      end
    end
  end else begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_b;
    assign in_ready       = out_ready;
    assign out_valid      = in_valid;
    assign out_data       = in_data;
  end

endmodule

// File: rtl/hybridift_axi_slice128.sv
// Register slice on all five AXI channels between the CPU (*_s0) and
// hybridift_axi_slave128 (*_m0).
// Every valid/ready path between the CPU and the slave is cut.
// Each channel still carries one beat per cycle and keeps beat order.
// Ports:
//   pll_core_cpuclk, pad_cpu_rst_b   clock and asynchronous active-low reset
//   aw/w/ar *_s0  inputs from the CPU     -> aw/w/ar *_m0 outputs to the slave
//   b/r *_m0      inputs from the slave   -> b/r *_s0 outputs to the CPU
// Each *_SLICE parameter selects registered (1) or wire (0) for that channel.
module hybridift_axi_slice128
  import hybridift_axi128_pkg::*;
#(
  parameter bit AW_SLICE = 1'b1,
  parameter bit W_SLICE  = 1'b1,
  parameter bit B_SLICE  = 1'b1,
  parameter bit AR_SLICE = 1'b1,
  parameter bit R_SLICE  = 1'b1
) (
  input  logic              pll_core_cpuclk,
  input  logic              pad_cpu_rst_b,
  // AW, CPU side
  input  logic              awvalid_s0,
  output logic              awready_s0,
  input  logic [ID_W-1:0]   awid_s0,
  input  logic [ADDR_W-1:0] awaddr_s0,
  input  logic [7:0]        awlen_s0,
  input  logic [2:0]        awsize_s0,
  input  logic [1:0]        awburst_s0,
  input  logic [3:0]        awcache_s0,
  input  logic [2:0]        awprot_s0,
  // W, CPU side
  input  logic              wvalid_s0,
  output logic              wready_s0,
  input  logic [ID_W-1:0]   wid_s0,
  input  logic [DATA_W-1:0] wdata_s0,
  input  logic [STRB_W-1:0] wstrb_s0,
  input  logic              wlast_s0,
  // B, CPU side
  output logic              bvalid_s0,
  input  logic              bready_s0,
  output logic [ID_W-1:0]   bid_s0,
  output logic [1:0]        bresp_s0,
  // AR, CPU side
  input  logic              arvalid_s0,
  output logic              arready_s0,
  input  logic [ID_W-1:0]   arid_s0,
  input  logic [ADDR_W-1:0] araddr_s0,
  input  logic [7:0]        arlen_s0,
  input  logic [2:0]        arsize_s0,
  input  logic [1:0]        arburst_s0,
  input  logic [3:0]        arcache_s0,
  input  logic [2:0]        arprot_s0,
  // R, CPU side
  output logic              rvalid_s0,
  input  logic              rready_s0,
  output logic [ID_W-1:0]   rid_s0,
  output logic [DATA_W-1:0] rdata_s0,
  output logic [1:0]        rresp_s0,
  output logic              rlast_s0,
  // AW, slave side
  output logic              awvalid_m0,
  input  logic              awready_m0,
  output logic [ID_W-1:0]   awid_m0,
  output logic [ADDR_W-1:0] awaddr_m0,
  output logic [7:0]        awlen_m0,
  output logic [2:0]        awsize_m0,
  output logic [1:0]        awburst_m0,
  output logic [3:0]        awcache_m0,
  output logic [2:0]        awprot_m0,
  // W, slave side
  output logic              wvalid_m0,
  input  logic              wready_m0,
  output logic [ID_W-1:0]   wid_m0,
  output logic [DATA_W-1:0] wdata_m0,
  output logic [STRB_W-1:0] wstrb_m0,
  output logic              wlast_m0,
  // B, slave side
  input  logic              bvalid_m0,
  output logic              bready_m0,
  input  logic [ID_W-1:0]   bid_m0,
  input  logic [1:0]        bresp_m0,
  // AR, slave side
  output logic              arvalid_m0,
  input  logic              arready_m0,
  output logic [ID_W-1:0]   arid_m0,
  output logic [ADDR_W-1:0] araddr_m0,
  output logic [7:0]        arlen_m0,
  output logic [2:0]        arsize_m0,
  output logic [1:0]        arburst_m0,
  output logic [3:0]        arcache_m0,
  output logic [2:0]        arprot_m0,
  // R, slave side
  input  logic              rvalid_m0,
  output logic              rready_m0,
  input  logic [ID_W-1:0]   rid_m0,
  input  logic [DATA_W-1:0] rdata_m0,
  input  logic [1:0]        rresp_m0,
  input  logic              rlast_m0
);

  aw_chan_t aw_in, aw_out;
  w_chan_t  w_in,  w_out;
  b_chan_t  b_in,  b_out;
  ar_chan_t ar_in, ar_out;
  r_chan_t  r_in,  r_out;

  assign aw_in = {awid_s0, awaddr_s0, awlen_s0, awsize_s0, awburst_s0, awcache_s0, awprot_s0};
  assign {awid_m0, awaddr_m0, awlen_m0, awsize_m0, awburst_m0, awcache_m0, awprot_m0} = aw_out;

  assign w_in = {wid_s0, wdata_s0, wstrb_s0, wlast_s0};
  assign {wid_m0, wdata_m0, wstrb_m0, wlast_m0} = w_out;

  assign b_in = {bid_m0, bresp_m0};
  assign {bid_s0, bresp_s0} = b_out;

  assign ar_in = {arid_s0, araddr_s0, arlen_s0, arsize_s0, arburst_s0, arcache_s0, arprot_s0};
  assign {arid_m0, araddr_m0, arlen_m0, arsize_m0, arburst_m0, arcache_m0, arprot_m0} = ar_out;

  assign r_in = {rid_m0, rdata_m0, rresp_m0, rlast_m0};
  assign {rid_s0, rdata_s0, rresp_s0, rlast_s0} = r_out;

  hybridift_axi_skid #(.T(aw_chan_t), .SLICE(AW_SLICE)) u_aw (
    .clk(pll_core_cpuclk), .rst_b(pad_cpu_rst_b),
    .in_valid(awvalid_s0), .in_ready(awready_s0), .in_data(aw_in),
    .out_valid(awvalid_m0), .out_ready(awready_m0), .out_data(aw_out));

  hybridift_axi_skid #(.T(w_chan_t), .SLICE(W_SLICE)) u_w (
    .clk(pll_core_cpuclk), .rst_b(pad_cpu_rst_b),
    .in_valid(wvalid_s0), .in_ready(wready_s0), .in_data(w_in),
    .out_valid(wvalid_m0), .out_ready(wready_m0), .out_data(w_out));

  hybridift_axi_skid #(.T(b_chan_t), .SLICE(B_SLICE)) u_b (
    .clk(pll_core_cpuclk), .rst_b(pad_cpu_rst_b),
    .in_valid(bvalid_m0), .in_ready(bready_m0), .in_data(b_in),
    .out_valid(bvalid_s0), .out_ready(bready_s0), .out_data(b_out));

  hybridift_axi_skid #(.T(ar_chan_t), .SLICE(AR_SLICE)) u_ar (
    .clk(pll_core_cpuclk), .rst_b(pad_cpu_rst_b),
    .in_valid(arvalid_s0), .in_ready(arready_s0), .in_data(ar_in),
    .out_valid(arvalid_m0), .out_ready(arready_m0), .out_data(ar_out));

  hybridift_axi_skid #(.T(r_chan_t), .SLICE(R_SLICE)) u_r (
    .clk(pll_core_cpuclk), .rst_b(pad_cpu_rst_b),
    .in_valid(rvalid_m0), .in_ready(rready_m0), .in_data(r_in),
    .out_valid(rvalid_s0), .out_ready(rready_s0), .out_data(r_out));

endmodule
